// File: rtl/sampler_pkg.sv
// Shared types and arithmetic helpers for the sampler voice mixer.
package sampler_pkg;

  typedef enum logic [1:0] {ACCUM, DRAIN, SAT, WRITE} mix_state_e;

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Headroom: full gain range plus one bit per doubling of voice count.
  function automatic int acc_width(input int sample_w, input int gain_w, input int id_w);
    return sample_w + gain_w + id_w + 1;
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int sample_w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (sample_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sampler_voice_mixer_channel.sv
// One audio channel: gain multiply, frame accumulate, clamp to sample range.
module mixer_sat_channel
  import sampler_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int GAIN_WIDTH   = 8,
  parameter int ID_WIDTH     = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic        [GAIN_WIDTH-1:0]   gain_i,
  input  logic                           in_vld_i,
  input  logic                           acc_clr_i,
  output logic signed [SAMPLE_WIDTH-1:0] sat_o,
  output logic                           clip_o
);

  localparam int AW = acc_width(SAMPLE_WIDTH, GAIN_WIDTH, ID_WIDTH);
  localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH + 1;

  logic signed [PW-1:0] prod_full;
  logic signed [AW-1:0] prod_d, prod_q, acc_q;
  logic                 vld_q;
  logic signed [63:0]   acc_ext, sat_ext;

  assign prod_full = sample_i * $signed({1'b0, gain_i});
  assign prod_d    = AW'(prod_full >>> (GAIN_WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prod_q <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_vld_i;
      if (in_vld_i) prod_q <= prod_d;
      if (acc_clr_i)  acc_q <= '0;
      else if (vld_q) acc_q <= acc_q + prod_q;
    end
  end

  assign acc_ext = 64'(acc_q);
  assign sat_ext = sat_val(acc_ext, SAMPLE_WIDTH);
  assign sat_o   = sat_ext[SAMPLE_WIDTH-1:0];
  assign clip_o  = (sat_ext != acc_ext);

endmodule

// File: rtl/sampler_voice_mixer.sv
// Frame mixer: sums gain-scaled voice beats until tlast, then clamps and writes one stereo word.
module sampler_voice_mixer
  import sampler_pkg::*;
#(
  parameter int NUM_VOICES   = 8,
  parameter int SAMPLE_WIDTH = 24,
  parameter int GAIN_WIDTH   = 8,
  parameter int ID_WIDTH     = $clog2(NUM_VOICES)
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [63:0]               s_axis_tdata,
  input  logic [ID_WIDTH-1:0]       s_axis_tid,
  input  logic                      s_axis_tlast,
  input  logic                      gain_wr,
  input  logic [ID_WIDTH-1:0]       gain_addr,
  input  logic [GAIN_WIDTH-1:0]     gain_data,
  input  logic [NUM_VOICES-1:0]     mute_mask,
  output logic [2*SAMPLE_WIDTH-1:0] data_out,
  output logic                      data_wr,
  input  logic                      fifo_full,
  output logic [15:0]               clip_count,
  output logic                      bad_id,
  input  logic                      clear_status
);

  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(GAIN_WIDTH));

  mix_state_e state_q, state_d;
  logic [NUM_VOICES-1:0][GAIN_WIDTH-1:0] gain_q;
  logic [1:0]                            last_pipe_q;
  logic [1:0][SAMPLE_WIDTH-1:0]          sat_w;
  logic [1:0]                            clip_w;
  logic [2*SAMPLE_WIDTH-1:0]             data_out_q;
  logic [15:0]                           clip_cnt_q;
  logic                                  bad_id_q;
  logic                                  accept, tid_ok, acc_clr, clip_inc;
  logic [ID_WIDTH-1:0]                   tid_idx;
  logic [GAIN_WIDTH-1:0]                 gain_eff;
  logic                                  unused_tdata;

  assign s_axis_tready = axis_aresetn && (state_q == ACCUM);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign tid_ok        = int'(s_axis_tid) < NUM_VOICES;
  assign tid_idx       = tid_ok ? s_axis_tid : '0;
  // Muted and out-of-range voices still flow through the pipe with zero gain.
  assign gain_eff      = (tid_ok && !mute_mask[tid_idx]) ? gain_q[tid_idx] : '0;
  assign unused_tdata  = ^{s_axis_tdata[63:32+SAMPLE_WIDTH], s_axis_tdata[31:SAMPLE_WIDTH]};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    mixer_sat_channel #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .GAIN_WIDTH  (GAIN_WIDTH),
      .ID_WIDTH    (ID_WIDTH)
    ) u_ch (
      .clk_i    (axis_aclk),
      .rst_ni   (axis_aresetn),
      .sample_i (s_axis_tdata[32*ch +: SAMPLE_WIDTH]),
      .gain_i   (gain_eff),
      .in_vld_i (accept),
      .acc_clr_i(acc_clr),
      .sat_o    (sat_w[ch]),
      .clip_o   (clip_w[ch])
    );
  end

  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    data_wr = 1'b0;
    unique case (state_q)
      ACCUM: if (accept && s_axis_tlast) state_d = DRAIN;
      DRAIN: if (last_pipe_q[1]) state_d = SAT;
      SAT:   state_d = WRITE;
      WRITE: if (!fifo_full) begin
        data_wr = 1'b1;
        acc_clr = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign clip_inc = (state_q == SAT) && (|clip_w);

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q     <= ACCUM;
      last_pipe_q <= '0;
      data_out_q  <= '0;
      clip_cnt_q  <= '0;
      bad_id_q    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) gain_q[v] <= UNITY;
    end else begin
      state_q     <= state_d;
      last_pipe_q <= {last_pipe_q[0], accept && s_axis_tlast};
      if (state_q == SAT) data_out_q <= sat_w;
      if (clip_inc)          clip_cnt_q <= (clip_cnt_q == 16'hFFFF) ? clip_cnt_q : clip_cnt_q + 16'd1;
      else if (clear_status) clip_cnt_q <= '0;
      if (accept && !tid_ok) bad_id_q <= 1'b1;
      else if (clear_status) bad_id_q <= 1'b0;
      if (gain_wr && int'(gain_addr) < NUM_VOICES) gain_q[gain_addr] <= gain_data;
    end
  end

  assign data_out   = data_out_q;
  assign clip_count = clip_cnt_q;
  assign bad_id     = bad_id_q;

endmodule
